// File: rtl/neuro_uart_pkg.sv
// neuro_uart_pkg: shared types and constants for the neurocore UART receiver.
//   state_e       - receiver FSM state encoding
//   OVS           - oversample ticks per bit
//   PH_S0..PH_S2  - bit phases at which the line is sampled (decision on PH_S2)
//   PH_END        - last phase of a bit
//   DATA_BITS     - data bits per frame
//   maj3()        - 2-of-3 majority vote
package neuro_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  localparam int         OVS       = 16;
  localparam int         DATA_BITS = 8;
  localparam logic [3:0] PH_S0     = 4'd7;
  localparam logic [3:0] PH_S1     = 4'd8;
  localparam logic [3:0] PH_S2     = 4'd9;
  localparam logic [3:0] PH_END    = 4'(OVS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/neuro_uart_rx_baud_tick.sv
// neuro_baud_tick: 16x oversample tick generator.
//   clk      in  - system clock
//   rst_n    in  - asynchronous active-low reset
//   restart  in  - synchronous clear; holds the counter at 0 while asserted
//   tick     out - one-cycle strobe every CLKS_PER_TICK cycles after restart drops
module neuro_baud_tick #(
  parameter int CLKS_PER_TICK = 65
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  logic [11:0] cnt_q, cnt_d;
  logic        at_end;

  assign at_end = (cnt_q == 12'(CLKS_PER_TICK - 1));
  // Gated by restart so no stale strobe can leak into the first idle cycle.
  assign tick   = at_end & ~restart;

  always_comb begin
    cnt_d = cnt_q + 12'd1;
    if (restart || at_end) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/neuro_uart_rx.sv
// neuro_uart_rx: oversampled UART receiver with a one-entry valid/ready output.
// Optional feature macro: NEURO_UART_RX_PARITY_EN (8E1 frame with parity check;
// default build is 8N1 and parity_err is tied low).
//   clk        in  - system clock
//   rst_n      in  - asynchronous active-low reset
//   rxd        in  - raw serial line, idle high, asynchronous
//   rx_data    out - received byte, stable while rx_valid
//   rx_valid   out - byte held until rx_valid & rx_ready
//   rx_ready   in  - consumer accept
//   frame_err  out - pulse: stop bit sampled low
//   parity_err out - pulse: parity mismatch (macro builds only)
//   overrun    out - pulse: byte completed while holding register full
//   busy       out - FSM not idle
module neuro_uart_rx
  import neuro_uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 65
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  logic       rxd_meta_q, rxd_sync_q;
  state_e     state_q, state_d;
  logic [3:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       tick, restart, maj, decide, bit_end, commit;
`ifdef NEURO_UART_RX_PARITY_EN
  logic       perr_flag_q, perr_flag_d;
  logic       perr_q, perr_d;
`endif

  // Counter is held in IDLE so bit phase starts at the detected falling edge.
  assign restart = (state_q == ST_IDLE);

  neuro_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // samp_q holds the phase-7/8 samples; the third vote is the live line at phase 9.
  assign maj     = maj3(samp_q[1], samp_q[0], rxd_sync_q);
  assign decide  = tick && (ph_q == PH_S2);
  assign bit_end = tick && (ph_q == PH_END);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    commit  = 1'b0;
`ifdef NEURO_UART_RX_PARITY_EN
    perr_flag_d = perr_flag_q;
    perr_d      = 1'b0;
`endif

    if (valid_q && rx_ready) valid_d = 1'b0;

    if (tick) begin
      ph_d = ph_q + 4'd1;
      if (ph_q == PH_S0) samp_d[1] = rxd_sync_q;
      if (ph_q == PH_S1) samp_d[0] = rxd_sync_q;
    end

    case (state_q)
      ST_IDLE: begin
        ph_d  = '0;
        bit_d = '0;
        if (!rxd_sync_q) state_d = ST_START;
      end
      ST_START: begin
        if (decide && maj)  state_d = ST_IDLE;
        else if (bit_end)   state_d = ST_DATA;
      end
      ST_DATA: begin
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (bit_end) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef NEURO_UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef NEURO_UART_RX_PARITY_EN
      ST_PARITY: begin
        // Even parity: the parity bit must equal the XOR of the data bits.
        if (decide)  perr_flag_d = maj ^ (^shift_q);
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (decide) begin
          state_d = ST_IDLE;
          if (!maj) begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
`ifdef NEURO_UART_RX_PARITY_EN
          end else if (perr_flag_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            commit = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A handshake in the same cycle frees the holding register for the new byte.
    if (commit) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef NEURO_UART_RX_PARITY_EN
      perr_flag_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef NEURO_UART_RX_PARITY_EN
      perr_flag_q <= perr_flag_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef NEURO_UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/neuro_uart_rx.md
# neuro_uart_rx

Serial receive front end for the neurocore: deserialises 8N1 UART frames from the `rxd` pad into bytes and presents them to `NeuralChip` over a one-entry valid/ready interface. It sits directly upstream of the chip's command decoder. It replaces the raw RXD pin feed with a synchronised, oversampled, error-flagged byte stream.

## Interface
- `CLKS_PER_TICK`, 65: clk cycles per 16x oversample tick (10 MHz / (9600 × 16) ≈ 65); legal range 2..4095.
- `clk`  in  1: single clock, all logic rising-edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `rxd`  in  1: raw serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8: received byte, stable while `rx_valid`=1.
- `rx_valid`  out  1: byte held; stays high until accepted.
- `rx_ready`  in  1: consumer accepts when `rx_valid & rx_ready`.
- `frame_err`  out  1: one-cycle pulse, stop bit sampled low.
- `parity_err`  out  1: one-cycle pulse, parity mismatch (see Configuration).
- `overrun`  out  1: one-cycle pulse, byte completed while holding register full.
- `busy`  out  1: high whenever FSM is not IDLE.

## Operation
- Input: 2-flop synchroniser on `rxd`, both flops reset to 1.
- Tick generator: counter 0..CLKS_PER_TICK-1, `tick` when counter = CLKS_PER_TICK-1; held at 0 in IDLE, released on start detect so bit phase aligns to the falling edge.
- Bit-phase counter `ph` 0..15 advances on each tick; `ph`=15 ends a bit.
- Sampling: synchronised line sampled at `ph` = 7, 8, 9; bit value = 2-of-3 majority, decided on the `ph`=9 tick.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: synchronised line = 0 → START, `ph`=0.
  - START: majority = 1 → IDLE (glitch rejected, no flags); else continue to `ph`=15 → DATA.
  - DATA: 8 bits, LSB first, shifted into a shift register; after bit 7 at `ph`=15 → PARITY or STOP.
  - PARITY: sample, compare with even parity of data; at `ph`=15 → STOP.
  - STOP: at `ph`=9 decision: 1 → commit byte, → IDLE; 0 → `frame_err` pulse, byte discarded, → BREAK.
  - BREAK: wait for synchronised line = 1 → IDLE.
- Commit: holding register empty (or freed by a handshake this same cycle) → load `rx_data`, set `rx_valid`; otherwise `overrun` pulse, new byte dropped, held byte unchanged.
- Parity error: byte discarded, `parity_err` pulse at STOP decision, stop bit still checked; frame error has priority if both (only `frame_err` pulses).
- `rx_valid` falls the cycle after `rx_valid & rx_ready`.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, all error pulses 0, `busy`=0, FSM IDLE, counters 0.
- Start detect: 2 cycles sync latency + 1 cycle to enter START.
- Commit: `rx_valid` high 1 cycle after the STOP `ph`=9 tick; error pulses on the same cycle `rx_valid` would rise.
- Return to IDLE immediately at commit, so a following start bit is detected from mid stop bit onward (tolerates +/-3% baud skew).
- `rx_ready` may be held high permanently; back-to-back frames never overrun then.
- `rst_n` assertion mid-frame: immediate return to IDLE, partial byte lost, `rx_valid` cleared.

## Configuration
- `NEURO_UART_RX_PARITY_EN` defined: 8E1 frame, PARITY state present, `parity_err` active.
- Undefined: 8N1, PARITY state absent, `parity_err` tied 0; frame time 10 bits.

## Structure
- Package `neuro_uart_pkg`: FSM state enum, `OVS`=16, sample phases 7/8/9, `DATA_BITS`=8.
- Sub-module `neuro_baud_tick`: tick counter with synchronous `restart` input and `tick` output; everything else in `neuro_uart_rx`.

## Test plan
- CLKS_PER_TICK=4, `rx_ready`=1, send 0xA5 8N1 → `rx_valid` one cycle, `rx_data`=0xA5, no flags, `busy` low after.
- `rx_ready`=0, send 0x3C then 0x81 → `rx_data` stays 0x3C, `overrun` pulses once at second commit; raise `rx_ready` → handshake, `rx_valid` drops.
- Stop bit driven 0 for 0x55, line held low 3 bit times → `frame_err` pulse, no `rx_valid`, FSM in BREAK until line high; next 0x12 received cleanly.
- Low glitch 2 ticks long on idle line → returns to IDLE, no `rx_valid`, no flags.
- Macro defined, send 0x07 with wrong parity bit 0 → `parity_err` pulse, no byte; correct parity bit 1 → `rx_data`=0x07.
- `rst_n` pulsed low during data bit 4 → `busy`=0, `rx_valid`=0; subsequent 0xFF received correctly.
